// File: rtl/regbank_wb_scheduler.sv
// Write-back scheduler for the register bank: arbitrates ALU (A) and held long-latency (B)
// results, keeps a busy scoreboard and flags read hazards. Define WB_BYPASS_EN to forward in-flight data.
module regbank_wb_scheduler #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   input  logic              iss_valid,
   output logic              iss_ready,
   input  logic [ADDR_W-1:0] iss_addr,
   input  logic [ADDR_W-1:0] rd1_addr,
   input  logic [ADDR_W-1:0] rd2_addr,
   output logic              hazard,
   output logic              wb_en,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              fwd1_valid,
   output logic              fwd2_valid,
   output logic [DATA_W-1:0] fwd1_data,
   output logic [DATA_W-1:0] fwd2_data
);

   localparam int          DEPTH      = 2 ** ADDR_W;
   localparam logic [3:0]  MAX_WAIT_C = 4'(MAX_WAIT);
   localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};

   logic [DEPTH-1:0]  busy_r;
   logic [DEPTH-1:0]  busy_nxt_s;
   logic              hold_valid_r;
   logic [ADDR_W-1:0] hold_addr_r;
   logic [DATA_W-1:0] hold_data_r;
   logic [3:0]        wait_r;
   logic              starve_s;
   logic              waw_s;
   logic              a_win_s;
   logic              b_win_s;
   logic              iss_set_s;
   logic              hz1_s;
   logic              hz2_s;

   // Arbitration: A wins by default, unless the starvation or WAW guard blocks it
   always_comb begin
      starve_s  = hold_valid_r && (wait_r == MAX_WAIT_C);
      waw_s     = busy_r[a_addr] && (a_addr != ZERO_A);
      a_ready   = !starve_s && !waw_s;
      a_win_s   = a_valid && a_ready;
      b_win_s   = hold_valid_r && !a_win_s;
      b_ready   = !hold_valid_r;
      iss_ready = !busy_r[iss_addr];
      iss_set_s = iss_valid && iss_ready && (iss_addr != ZERO_A);
   end

   // Scoreboard next state: a B commit clears, a same-cycle issue to that address re-sets
   always_comb begin
      busy_nxt_s = busy_r;
      for (int i = 0; i < DEPTH; i++) begin
         busy_nxt_s[i] = (busy_r[i] && !(b_win_s && (hold_addr_r == ADDR_W'(i))))
                         || (iss_set_s && (iss_addr == ADDR_W'(i)));
      end
   end

   // Scoreboard, hold register and wait counter state
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r       <= {DEPTH{1'b0}};
         hold_valid_r <= 1'b0;
         hold_addr_r  <= ZERO_A;
         hold_data_r  <= {DATA_W{1'b0}};
         wait_r       <= 4'd0;
      end else begin
         busy_r <= busy_nxt_s;
         if (b_win_s) begin
            hold_valid_r <= 1'b0;
            wait_r       <= 4'd0;
         end else if (hold_valid_r) begin
            wait_r       <= wait_r + 4'd1;
         end else if (b_valid) begin
            hold_valid_r <= 1'b1;
            hold_addr_r  <= b_addr;
            hold_data_r  <= b_data;
            wait_r       <= 4'd0;
         end else begin
            wait_r       <= 4'd0;
         end
      end
   end

   // Commit register driving the bank write port; address 0 commits are silent
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_en   <= 1'b0;
         wb_addr <= ZERO_A;
         wb_data <= {DATA_W{1'b0}};
      end else if (a_win_s) begin
         wb_en   <= (a_addr != ZERO_A);
         wb_addr <= a_addr;
         wb_data <= a_data;
      end else if (b_win_s) begin
         wb_en   <= (hold_addr_r != ZERO_A);
         wb_addr <= hold_addr_r;
         wb_data <= hold_data_r;
      end else begin
         wb_en   <= 1'b0;
      end
   end

   // Read hazards and in-flight forwarding
   always_comb begin
`ifdef WB_BYPASS_EN
      fwd1_valid = wb_en && (rd1_addr == wb_addr) && (rd1_addr != ZERO_A);
      fwd2_valid = wb_en && (rd2_addr == wb_addr) && (rd2_addr != ZERO_A);
      fwd1_data  = fwd1_valid ? wb_data : {DATA_W{1'b0}};
      fwd2_data  = fwd2_valid ? wb_data : {DATA_W{1'b0}};
      hz1_s      = (rd1_addr != ZERO_A) && busy_r[rd1_addr];
      hz2_s      = (rd2_addr != ZERO_A) && busy_r[rd2_addr];
`else
      fwd1_valid = 1'b0;
      fwd2_valid = 1'b0;
      fwd1_data  = {DATA_W{1'b0}};
      fwd2_data  = {DATA_W{1'b0}};
      hz1_s      = (rd1_addr != ZERO_A)
                   && (busy_r[rd1_addr] || (wb_en && (rd1_addr == wb_addr)));
      hz2_s      = (rd2_addr != ZERO_A)
                   && (busy_r[rd2_addr] || (wb_en && (rd2_addr == wb_addr)));
`endif
      hazard = hz1_s || hz2_s;
   end

endmodule

// File: tb/tb_regbank_wb_scheduler.sv
// Directed self-checking bench for regbank_wb_scheduler (default MAX_WAIT=4).
module tb_regbank_wb_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid, a_ready, b_valid, b_ready, iss_valid, iss_ready, hazard;
   logic [4:0]  a_addr, b_addr, iss_addr, rd1_addr, rd2_addr, wb_addr;
   logic [31:0] a_data, b_data, wb_data, fwd1_data, fwd2_data;
   logic        wb_en, fwd1_valid, fwd2_valid;
   int          total  = 0;
   int          passed = 0;
   int          fails  = 0;

   regbank_wb_scheduler dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_addr(iss_addr),
      .rd1_addr(rd1_addr), .rd2_addr(rd2_addr), .hazard(hazard),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid),
      .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; iss_valid = 1'b0;
      a_addr = 5'd0; b_addr = 5'd0; iss_addr = 5'd0; rd1_addr = 5'd0; rd2_addr = 5'd0;
      a_data = 32'h0; b_data = 32'h0;
      step(); step();
      rst = 1'b0; #1;
      chk("rst_wb_en", 32'(wb_en), 32'd0);
      chk("rst_wb_addr", 32'(wb_addr), 32'd0);
      chk("rst_b_ready", 32'(b_ready), 32'd1);
      chk("rst_fwd1", 32'(fwd1_valid), 32'd0);

      // reset mid-operation: busy[3] and B held at 3
      iss_valid = 1'b1; iss_addr = 5'd3; step(); iss_valid = 1'b0;
      b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h33; step();
      b_valid = 1'b0; a_valid = 1'b1; a_addr = 5'd9; rd1_addr = 5'd3; #1;
      chk("mid_b_ready", 32'(b_ready), 32'd0);
      chk("mid_iss_ready", 32'(iss_ready), 32'd0);
      chk("mid_hazard", 32'(hazard), 32'd1);
      rst = 1'b1; a_valid = 1'b0; step(); rst = 1'b0; #1;
      chk("rr_b_ready", 32'(b_ready), 32'd1);
      chk("rr_wb_en", 32'(wb_en), 32'd0);
      chk("rr_iss_ready", 32'(iss_ready), 32'd1);
      chk("rr_hazard", 32'(hazard), 32'd0);
      rd1_addr = 5'd0;

      // A-only write: single pulse
      a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF; #1;
      chk("a_ready", 32'(a_ready), 32'd1);
      step(); a_valid = 1'b0;
      chk("a_wb_en", 32'(wb_en), 32'd1);
      chk("a_wb_addr", 32'(wb_addr), 32'd5);
      chk("a_wb_data", wb_data, 32'hDEADBEEF);
      step();
      chk("a_pulse_end", 32'(wb_en), 32'd0);

      // starvation: B held at 7 while A streams to 9
      b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h77; step();
      b_valid = 1'b0; a_valid = 1'b1; a_addr = 5'd9;
      for (int i = 0; i < 4; i++) begin
         a_data = 32'h90 + 32'(i); #1;
         chk("stv_a_ready", 32'(a_ready), 32'd1);
         step();
         chk("stv_a_commit", 32'(wb_addr), 32'd9);
         chk("stv_a_data", wb_data, 32'h90 + 32'(i));
      end
      chk("stv_blocked", 32'(a_ready), 32'd0);
      chk("stv_hold_full", 32'(b_ready), 32'd0);
      step();
      chk("stv_b_en", 32'(wb_en), 32'd1);
      chk("stv_b_addr", 32'(wb_addr), 32'd7);
      chk("stv_b_data", wb_data, 32'h77);
      chk("stv_b_free", 32'(b_ready), 32'd1);
      chk("stv_a_resume", 32'(a_ready), 32'd1);
      step();
      chk("stv_a_again", 32'(wb_addr), 32'd9);
      a_valid = 1'b0; step();

      // scoreboard on register 12
      iss_valid = 1'b1; iss_addr = 5'd12; #1;
      chk("sb_iss_ready", 32'(iss_ready), 32'd1);
      step(); iss_valid = 1'b0; rd2_addr = 5'd12; a_valid = 1'b1; a_addr = 5'd12; #1;
      chk("sb_hazard", 32'(hazard), 32'd1);
      chk("sb_waw", 32'(a_ready), 32'd0);
      chk("sb_iss_busy", 32'(iss_ready), 32'd0);
      a_valid = 1'b0; b_valid = 1'b1; b_addr = 5'd12; b_data = 32'hC0; step();
      b_valid = 1'b0;
      chk("sb_hazard_held", 32'(hazard), 32'd1);
      step();
      chk("sb_b_en", 32'(wb_en), 32'd1);
      chk("sb_b_addr", 32'(wb_addr), 32'd12);
      chk("sb_b_data", wb_data, 32'hC0);
      chk("sb_iss_free", 32'(iss_ready), 32'd1);
      chk("sb_a_free", 32'(a_ready), 32'd1);
`ifdef WB_BYPASS_EN
      chk("sb_inflight_hz", 32'(hazard), 32'd0);
      chk("sb_fwd2", fwd2_data, 32'hC0);
`else
      chk("sb_inflight_hz", 32'(hazard), 32'd1);
`endif
      step();
      chk("sb_clear_hz", 32'(hazard), 32'd0);
      rd2_addr = 5'd0;

      // register 0: accepted, never written, never hazarded
      a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h1;
      b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h2; #1;
      chk("r0_a_ready", 32'(a_ready), 32'd1);
      chk("r0_b_ready", 32'(b_ready), 32'd1);
      step(); a_valid = 1'b0; b_valid = 1'b0;
      iss_valid = 1'b1; iss_addr = 5'd0; rd1_addr = 5'd0; #1;
      chk("r0_a_wb_en", 32'(wb_en), 32'd0);
      chk("r0_b_taken", 32'(b_ready), 32'd0);
      chk("r0_iss_ready", 32'(iss_ready), 32'd1);
      step(); iss_valid = 1'b0;
      chk("r0_b_wb_en", 32'(wb_en), 32'd0);
      chk("r0_b_free", 32'(b_ready), 32'd1);
      chk("r0_hazard", 32'(hazard), 32'd0);

      // in-flight read of register 4
      a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h11; step();
      a_valid = 1'b0; rd1_addr = 5'd4; #1;
      chk("byp_wb_en", 32'(wb_en), 32'd1);
      chk("byp_wb_addr", 32'(wb_addr), 32'd4);
`ifdef WB_BYPASS_EN
      chk("byp_fwd1_valid", 32'(fwd1_valid), 32'd1);
      chk("byp_fwd1_data", fwd1_data, 32'h11);
      chk("byp_hazard", 32'(hazard), 32'd0);
`else
      chk("byp_fwd1_valid", 32'(fwd1_valid), 32'd0);
      chk("byp_fwd1_data", fwd1_data, 32'h0);
      chk("byp_hazard", 32'(hazard), 32'd1);
`endif
      step();
      chk("byp_done_hz", 32'(hazard), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
